// File: rtl/dmem_responder.sv
// dmem_responder: target end of the pipeline data-memory bus.
// Serves byte/half/word/double loads and stores from an internal
// 64-bit-wide RAM after a fixed number of wait states, with lane steering,
// zero-extension and access-fault reporting.
//
// Handshake: the initiator raises dmem_rstrobe or dmem_wstrobe (level) and
// holds it; the responder latches the request on the first rising edge it
// sees in IDLE, pulses dmem_cycle_complete for exactly one cycle when the
// access is done, and will not accept another request until both strobes
// have been observed low for at least one edge.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] dmem_addr,
    input  logic [63:0] dmem_dout,
    output logic [63:0] dmem_din,
    input  logic [1:0]  dmem_write_width,
    input  logic        dmem_rstrobe,
    input  logic        dmem_wstrobe,
    output logic        dmem_cycle_complete,
    output logic        bus_error
);

    localparam int unsigned IDX_W = DEPTH_LOG2;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0]  WS8   = 8'(WAIT_STATES);

    // FSM state is kept in a named enum register so checkers can bind to it.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched request.
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [1:0]  width_q;
    logic        is_write_q;
    logic        both_q;
    logic [7:0]  cnt_q;

    // Decode of the live and latched addresses.
    logic             any_strobe;
    logic             accept;
    logic [63:0]      live_off;
    logic [63:0]      off_q;
    logic [IDX_W-1:0] live_idx;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] port_idx;
    logic [2:0]       lane_q;

    // ACK-time datapath.
    logic        ack;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;
    logic [7:0]  size_mask;
    logic [63:0] data_mask;
    logic [7:0]  byte_en;
    logic [63:0] wr_data;
    logic [63:0] rd_data;

    // RAM and its registered read port.
    logic [63:0] ram [0:DEPTH-1];
    logic [63:0] ram_q;

    assign any_strobe = dmem_rstrobe | dmem_wstrobe;
    assign accept     = (state_q == S_IDLE) && any_strobe;
    assign live_off   = dmem_addr - BASE_ADDR;
    assign off_q      = addr_q - BASE_ADDR;
    assign live_idx   = IDX_W'(live_off >> 3);
    assign idx_q      = IDX_W'(off_q >> 3);
    assign lane_q     = off_q[2:0];

    // The RAM read is issued at the accept edge from the live address so the
    // word is already in ram_q when ACK arrives, even with zero wait states.
    assign port_idx   = (state_q == S_IDLE) ? live_idx : idx_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_strobe) begin
                    state_d = (WS8 != 8'd0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!any_strobe) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ACK-time decode: fault detection, write lane enables, read extraction.
    always_comb begin
        ack = (state_q == S_ACK);
        case (width_q)
            2'd0: begin
                size_mask  = 8'h01;
                data_mask  = 64'h0000_0000_0000_00FF;
                misaligned = 1'b0;
            end
            2'd1: begin
                size_mask  = 8'h03;
                data_mask  = 64'h0000_0000_0000_FFFF;
                misaligned = lane_q[0];
            end
            2'd2: begin
                size_mask  = 8'h0F;
                data_mask  = 64'h0000_0000_FFFF_FFFF;
                misaligned = (lane_q[1:0] != 2'b00);
            end
            default: begin
                size_mask  = 8'hFF;
                data_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
                misaligned = (lane_q != 3'b000);
            end
        endcase
        // The subtraction may wrap for addresses below the base, so both
        // the raw compare and the offset bound are needed.
        out_of_range = (addr_q < BASE_ADDR) ||
                       ((off_q >> (DEPTH_LOG2 + 3)) != 64'd0);
        fault   = misaligned | out_of_range | both_q;
        byte_en = (ack && is_write_q && !fault) ? (size_mask << lane_q) : 8'h00;
        wr_data = wdata_q << {lane_q, 3'b000};
        rd_data = (ram_q >> {lane_q, 3'b000}) & data_mask;
    end

    // Request latch, wait counter and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q              <= 64'd0;
            wdata_q             <= 64'd0;
            width_q             <= 2'd0;
            is_write_q          <= 1'b0;
            both_q              <= 1'b0;
            cnt_q               <= 8'd0;
            dmem_din            <= 64'd0;
            dmem_cycle_complete <= 1'b0;
            bus_error           <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= dmem_addr;
                wdata_q    <= dmem_dout;
                width_q    <= dmem_write_width;
                is_write_q <= dmem_wstrobe & ~dmem_rstrobe;
                both_q     <= dmem_wstrobe & dmem_rstrobe;
                cnt_q      <= WS8;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 8'd1;
            end
            dmem_cycle_complete <= ack;
            bus_error           <= ack & fault;
            if (ack && !is_write_q) begin
                dmem_din <= fault ? 64'd0 : rd_data;
            end
        end
    end

    // Single-port RAM with per-byte write enable; contents survive reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (byte_en[k]) begin
                ram[port_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
        ram_q <= ram[port_idx];
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (target) end of the pipeline's data memory bus.
- Serves loads and stores from an internal 64-bit-wide RAM, with a programmable number of wait states.
- Used as the data memory in core-level simulation and FPGA builds; connects directly to the pipeline's dmem_* ports.
- Owns byte-lane steering, zero-extension, the completion handshake and access-error reporting.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 64-bit doublewords in the RAM (default 8 KiB).
- BASE_ADDR, 64'h0, byte address of doubleword 0; must be 8-byte aligned.
- WAIT_STATES, 1, extra cycles between accept and completion (0..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dmem_addr  input  64  byte address from the initiator.
- dmem_dout  input  64  store data from the initiator; least significant bytes used.
- dmem_din  output  64  load data to the initiator, zero-extended.
- dmem_write_width  input  2  access width: 0=8b, 1=16b, 2=32b, 3=64b. Applies to loads and stores.
- dmem_rstrobe  input  1  read request, level, held until completion.
- dmem_wstrobe  input  1  write request, level, held until completion.
- dmem_cycle_complete  output  1  one-cycle completion pulse.
- bus_error  output  1  one-cycle pulse coincident with completion of a faulted access.

Behaviour:
- Reset (async assert, sync release):
  - State returns to IDLE.
  - dmem_din=0, dmem_cycle_complete=0, bus_error=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset during WAIT/ACK abandons the access; a write that has not yet reached ACK is never performed.
- FSM states: IDLE, WAIT, ACK, RELEASE.
- IDLE:
  - On a rising edge with rstrobe|wstrobe=1, latch addr, dout, width and direction; load counter=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else ACK.
- WAIT: decrement counter each cycle; at 1, go to ACK.
- ACK:
  - Perform the RAM read or write at this edge.
  - Register dmem_din for reads; raise dmem_cycle_complete for exactly one cycle; go to RELEASE.
- RELEASE:
  - Wait until both strobes are low, then return to IDLE.
  - A strobe still held high never retriggers an access.
  - Minimum back-to-back spacing is one low-strobe cycle.
- Latency: strobe seen at edge N, complete high during cycle N+1+WAIT_STATES.
- dmem_din holds its value until the next completed read. Writes and faulted reads do not alter dmem_din, except that a faulted read drives 0.
- Address decode:
  - offset = latched addr - BASE_ADDR; word index = offset[DEPTH_LOG2+2:3]; lane = offset[2:0].
  - Little-endian: byte at lane k occupies RAM bits [8k+7:8k].
- Read: extract width bytes starting at lane k, place them in dmem_din low bits, zero the upper bits.
- Write: byte-enable only the width bytes starting at lane k, sourced from dmem_dout low bits. Other bytes are unchanged.
- Faults (access still completes; bus_error pulses with complete; no RAM write; read returns 0):
  - Misaligned: lane not a multiple of the access size (1/2/4/8).
  - Out of range: addr < BASE_ADDR or offset >= 8*2^DEPTH_LOG2, including 64-bit wrap of the subtraction.
  - rstrobe and wstrobe both high at accept.
- Strobes falling before completion are ignored; the latched access completes regardless.
- RAM is a single-port synchronous array with per-byte write enable, inferrable as block RAM.

Test Plan:
- Reset then 64b write addr=0x10 data=0x1122334455667788, then 64b read addr=0x10 with WAIT_STATES=1 -> complete pulses 2 cycles after each accept; din=0x1122334455667788; bus_error=0.
- Byte write 0xAB to addr=0x13 over the above word, then 64b read 0x10 -> din=0x11223344AB667788. 16b read at 0x16 -> din=0x0000000000001122.
- 32b read at addr=0x12 (misaligned) -> complete and bus_error pulse together, din=0. Following aligned read at 0x14 -> din=0x11223344.
- Write to addr=0x2000 with DEPTH_LOG2=10 (out of range) -> bus_error=1, no RAM change. Readback of 0x0 is unchanged.
- Strobe held high for 5 cycles after complete -> exactly one complete pulse. WAIT_STATES=0 -> complete in the cycle after accept.
- Assert rst_n=0 during WAIT of a write to 0x18 -> outputs 0 immediately; post-reset read of 0x18 returns the old data.
